// File: rtl/mips_pc_update_pkg.sv
// Shared types for the PC update slice: control encodings from the PC signal
// generator, the fetch FSM states, and the branch condition evaluator.
package mips_pc_update_pkg;

   localparam logic [31:0] PC_STEP = 32'd4;

   // Control-flow action requested by the decode-stage instruction.
   typedef enum logic [1:0] {
      PC_INC    = 2'd0,
      PC_JUMP   = 2'd1,
      PC_JUMPR  = 2'd2,
      PC_BRANCH = 2'd3
   } pc_action_e;

   // Branch condition; only meaningful together with PC_BRANCH.
   typedef enum logic [1:0] {
      COND_NONE = 2'd0,
      COND_EQ   = 2'd1,
      COND_NE   = 2'd2
   } pc_cond_e;

   typedef struct packed {
      pc_action_e action;
      pc_cond_e   cond;
   } pc_control_t;

   // RUN issues sequential/redirected fetches; PENDING holds a redirect that
   // instruction memory has not yet accepted.
   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_PENDING = 1'b1
   } pc_state_e;

   // COND_NONE is never true, so a branch without a condition acts as PC_INC.
   function automatic logic cond_true_f(input pc_cond_e c,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
      case (c)
         COND_EQ: return (a == b);
         COND_NE: return (a != b);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mips_pc_update_if.sv
// Decode/fetch signal bundle for the PC update block. The master side drives
// decode-stage control and memory handshake; the slave side is the PC block.
interface mips_pc_update_if;
   import mips_pc_update_pkg::*;

   pc_control_t control;
   logic        decode_valid;
   logic [31:0] decode_pc;
   logic [31:0] rs_value;
   logic [31:0] rt_value;
   logic [15:0] immediate;
   logic [25:0] target;
   logic        stall;
   logic        fetch_ready;

   logic [31:0] pc;
   logic        fetch_valid;
   logic        flush;
   logic        taken;

   modport master (
      output control, decode_valid, decode_pc, rs_value, rt_value,
             immediate, target, stall, fetch_ready,
      input  pc, fetch_valid, flush, taken
   );

   modport slave (
      input  control, decode_valid, decode_pc, rs_value, rt_value,
             immediate, target, stall, fetch_ready,
      output pc, fetch_valid, flush, taken
   );

endinterface

// File: rtl/mips_pc_update_target.sv
// Combinational redirect target and branch condition for the decode-stage
// instruction. Targets are always word aligned.
module mips_pc_update_target
   import mips_pc_update_pkg::*;
(
   input  pc_control_t control,
   input  logic [31:0] decode_pc,
   input  logic [31:0] rs_value,
   input  logic [31:0] rt_value,
   input  logic [15:0] immediate,
   input  logic [25:0] target,
   output logic [31:0] redirect_target,
   output logic        cond_true
);

   logic [31:0] pc_plus4;
   logic [31:0] br_off;
   logic [31:0] br_sum;

   // Select the target for the requested action; branch offset is a signed
   // word displacement from the delay-slot address.
   always_comb begin
      pc_plus4        = decode_pc + PC_STEP;
      br_off          = {{14{immediate[15]}}, immediate, 2'b00};
      br_sum          = pc_plus4 + br_off;
      cond_true       = cond_true_f(control.cond, rs_value, rt_value);
      redirect_target = {pc_plus4[31:2], 2'b00};
      unique case (control.action)
         PC_JUMP:   redirect_target = {pc_plus4[31:28], target, 2'b00};
         PC_JUMPR:  redirect_target = {rs_value[31:2], 2'b00};
         PC_BRANCH: redirect_target = {br_sum[31:2], 2'b00};
         default:   redirect_target = {pc_plus4[31:2], 2'b00};
      endcase
   end

endmodule

// File: rtl/mips_pc_update.sv
// Fetch PC register with decode-stage redirect. A redirect that memory cannot
// accept immediately is parked in PENDING until the fetch handshake completes.
module mips_pc_update
   import mips_pc_update_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
)(
   input  logic               clock,
   input  logic               reset,
   mips_pc_update_if.slave    bus
);

   pc_state_e   state_q;
   logic [31:0] pc_q;
   logic [31:0] pending_q;

   logic [31:0] redirect_target;
   logic        cond_true;
   logic        redirect;
   logic        fetch_valid;
   logic        flush;
   logic        in_run;

   mips_pc_update_target u_target (
      .control         (bus.control),
      .decode_pc       (bus.decode_pc),
      .rs_value        (bus.rs_value),
      .rt_value        (bus.rt_value),
      .immediate       (bus.immediate),
      .target          (bus.target),
      .redirect_target (redirect_target),
      .cond_true       (cond_true)
   );

   // Redirect decision and handshake outputs; all forced low while in reset.
   // Control inputs are ignored in PENDING, so a redirect is only seen in RUN.
   always_comb begin
      in_run      = (state_q == ST_RUN);
      redirect    = 1'b0;
      if (!reset && in_run && bus.decode_valid && !bus.stall) begin
         unique case (bus.control.action)
            PC_JUMP, PC_JUMPR: redirect = 1'b1;
            PC_BRANCH:         redirect = cond_true;
            default:           redirect = 1'b0;
         endcase
      end
      fetch_valid = !reset && (!in_run || !bus.stall);
      flush       = !reset && (in_run ? redirect : bus.fetch_ready);
   end

   // PC / pending-target state machine.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q      <= {RESET_PC[31:2], 2'b00};
         pending_q <= '0;
         state_q   <= ST_RUN;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (redirect) begin
                  if (bus.fetch_ready) begin
                     pc_q <= redirect_target;
                  end else begin
                     pending_q <= redirect_target;
                     state_q   <= ST_PENDING;
                  end
               end else if (fetch_valid && bus.fetch_ready) begin
                  pc_q <= pc_q + PC_STEP;
               end
            end
            ST_PENDING: begin
               if (bus.fetch_ready) begin
                  pc_q    <= pending_q;
                  state_q <= ST_RUN;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign bus.pc          = pc_q;
   assign bus.fetch_valid = fetch_valid;
   assign bus.flush       = flush;
   assign bus.taken       = redirect;

endmodule

// File: tb/tb_mips_pc_update.sv
// Vector-driven bench for mips_pc_update: each record gives decode inputs,
// the expected same-cycle outputs and the expected pc after the edge.
module tb_mips_pc_update;
   import mips_pc_update_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mips_pc_update_if bus_if();

   mips_pc_update #(.RESET_PC(32'h0040_0000)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus_if.slave)
   );

   typedef struct {
      pc_control_t ctrl;
      logic        dv;
      logic [31:0] dpc;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [15:0] imm;
      logic [25:0] tgt;
      logic        stall;
      logic        rdy;
      logic        e_taken;
      logic        e_flush;
      logic        e_fv;
      logic [31:0] e_pc;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] exp_q[$];
   int          errors = 0;
   int          checks = 0;

   function automatic vec_t mk(input pc_action_e a, input pc_cond_e c, input logic dv,
                               input logic [31:0] dpc, input logic [31:0] rs,
                               input logic [31:0] rt, input logic [15:0] imm,
                               input logic [25:0] tgt, input logic st, input logic rdy,
                               input logic et, input logic ef, input logic efv,
                               input logic [31:0] epc);
      vec_t v;
      v.ctrl.action = a; v.ctrl.cond = c; v.dv = dv; v.dpc = dpc; v.rs = rs; v.rt = rt;
      v.imm = imm; v.tgt = tgt; v.stall = st; v.rdy = rdy;
      v.e_taken = et; v.e_flush = ef; v.e_fv = efv; v.e_pc = epc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus_if.control      = v.ctrl;
      bus_if.decode_valid = v.dv;
      bus_if.decode_pc    = v.dpc;
      bus_if.rs_value     = v.rs;
      bus_if.rt_value     = v.rt;
      bus_if.immediate    = v.imm;
      bus_if.target       = v.tgt;
      bus_if.stall        = v.stall;
      bus_if.fetch_ready  = v.rdy;
   endtask

   // One cycle: drive, check same-cycle outputs, queue expected pc, then
   // pop and compare once the edge has updated the register.
   task automatic apply(input vec_t v, input logic do_rst, input string tag);
      @(negedge clk);
      rst = do_rst;
      drive(v);
      #1;
      chk({tag, " taken"},       32'(bus_if.taken),       32'(v.e_taken));
      chk({tag, " flush"},       32'(bus_if.flush),       32'(v.e_flush));
      chk({tag, " fetch_valid"}, 32'(bus_if.fetch_valid), 32'(v.e_fv));
      exp_q.push_back(v.e_pc);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         errors++; checks++;
         $display("FAIL %s pc: scoreboard empty", tag);
      end else begin
         chk({tag, " pc"}, bus_if.pc, exp_q.pop_front());
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(mk(PC_INC, COND_NONE, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

      // ---------------- main table (runs from a fresh reset) ----------------
      //            action     cond       dv dpc            rs             rt   imm       tgt           st rdy tk fl fv next pc
      vecs.push_back(mk(PC_INC,    COND_NONE, 0, 32'h0,        32'h0,        32'h0, 16'h0,    26'h0,       0, 1, 0, 0, 1, 32'h0040_0004));
      vecs.push_back(mk(PC_INC,    COND_NONE, 0, 32'h0,        32'h0,        32'h0, 16'h0,    26'h0,       0, 1, 0, 0, 1, 32'h0040_0008));
      vecs.push_back(mk(PC_INC,    COND_NONE, 0, 32'h0,        32'h0,        32'h0, 16'h0,    26'h0,       0, 1, 0, 0, 1, 32'h0040_000C));
      vecs.push_back(mk(PC_INC,    COND_NONE, 0, 32'h0,        32'h0,        32'h0, 16'h0,    26'h0,       0, 1, 0, 0, 1, 32'h0040_0010));
      // beq taken backwards: 0x00400014 - 16
      vecs.push_back(mk(PC_BRANCH, COND_EQ,   1, 32'h0040_0010, 32'd5,       32'd5, 16'hFFFC, 26'h0,       0, 1, 1, 1, 1, 32'h0040_0004));
      // beq not taken
      vecs.push_back(mk(PC_BRANCH, COND_EQ,   1, 32'h0040_0010, 32'd5,       32'd6, 16'hFFFC, 26'h0,       0, 1, 0, 0, 1, 32'h0040_0008));
      // bne taken forward: 0x00400024 + 16
      vecs.push_back(mk(PC_BRANCH, COND_NE,   1, 32'h0040_0020, 32'd5,       32'd6, 16'h0004, 26'h0,       0, 1, 1, 1, 1, 32'h0040_0034));
      // branch with no condition behaves as increment
      vecs.push_back(mk(PC_BRANCH, COND_NONE, 1, 32'h0040_0020, 32'd5,       32'd5, 16'h0004, 26'h0,       0, 1, 0, 0, 1, 32'h0040_0038));
      // memory not ready: hold
      vecs.push_back(mk(PC_INC,    COND_NONE, 0, 32'h0,        32'h0,        32'h0, 16'h0,    26'h0,       0, 0, 0, 0, 1, 32'h0040_0038));
      // jr with memory busy -> PENDING, pc holds
      vecs.push_back(mk(PC_JUMPR,  COND_NONE, 1, 32'h0040_0030, 32'h0040_0103, 32'h0, 16'h0,  26'h0,       0, 0, 1, 1, 1, 32'h0040_0038));
      // PENDING: stall and a fresh jump are ignored, still fetching
      vecs.push_back(mk(PC_JUMP,   COND_NONE, 1, 32'h0040_0034, 32'h0,       32'h0, 16'h0,    26'h0000010, 1, 0, 0, 0, 1, 32'h0040_0038));
      // PENDING accepted: flush stale fetch, load pending target
      vecs.push_back(mk(PC_JUMP,   COND_NONE, 1, 32'h0040_0034, 32'h0,       32'h0, 16'h0,    26'h0000010, 0, 1, 0, 1, 1, 32'h0040_0100));
      // jump under stall: no redirect, no fetch
      vecs.push_back(mk(PC_JUMP,   COND_NONE, 1, 32'h0040_0200, 32'h0,       32'h0, 16'h0,    26'h0100040, 1, 1, 0, 0, 0, 32'h0040_0100));
      // stall drops: jump to {0x0, 0x0100040, 00} = 0x00400100
      vecs.push_back(mk(PC_JUMP,   COND_NONE, 1, 32'h0040_0200, 32'h0,       32'h0, 16'h0,    26'h0100040, 0, 1, 1, 1, 1, 32'h0040_0100));
      // decode not valid: jump ignored
      vecs.push_back(mk(PC_JUMP,   COND_NONE, 0, 32'h0040_0200, 32'h0,       32'h0, 16'h0,    26'h0100040, 0, 1, 0, 0, 1, 32'h0040_0104));
      // jump to top of address space (region from decode_pc+4)
      vecs.push_back(mk(PC_JUMP,   COND_NONE, 1, 32'hF000_0000, 32'h0,       32'h0, 16'h0,    26'h3FFFFFF, 0, 1, 1, 1, 1, 32'hFFFF_FFFC));
      // sequential wrap
      vecs.push_back(mk(PC_INC,    COND_NONE, 0, 32'h0,        32'h0,        32'h0, 16'h0,    26'h0,       0, 1, 0, 0, 1, 32'h0000_0000));

      // reset cycle: outputs low even with a jr presented
      apply(mk(PC_JUMPR, COND_NONE, 1, 32'h0, 32'h1234_5678, 32'h0, 16'h0, 26'h0, 0, 1, 0, 0, 0, 32'h0040_0000), 1'b1, "reset");
      foreach (vecs[i]) apply(vecs[i], 1'b0, $sformatf("vec%0d", i));

      // ---------------- reset while a redirect is pending ----------------
      apply(mk(PC_JUMPR, COND_NONE, 1, 32'h0, 32'h1234_5678, 32'h0, 16'h0, 26'h0, 0, 0, 1, 1, 1, 32'h0000_0000), 1'b0, "pend_enter");
      apply(mk(PC_INC,   COND_NONE, 0, 32'h0, 32'h0,         32'h0, 16'h0, 26'h0, 0, 1, 0, 0, 0, 32'h0040_0000), 1'b1, "pend_reset");
      apply(mk(PC_INC,   COND_NONE, 0, 32'h0, 32'h0,         32'h0, 16'h0, 26'h0, 0, 1, 0, 0, 1, 32'h0040_0004), 1'b0, "post_reset");

      if (exp_q.size() != 0) begin
         errors++; checks++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
